pe_mux_seq: RTL

PE_MUX_SEQ -- requirements
Module: pe_mux_seq

---
 rtl/pe_mux_seq_if.sv | 29 ++
 rtl/pe_mux_seq.sv | 96 +++++++++
 2 files changed

// File: rtl/pe_mux_seq_if.sv
// Bus bundle for pe_mux_seq: input vector beat and selected output beat.
interface pe_mux_seq_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SEL_WIDTH = $clog2(DEPTH)
);
    logic [WIDTH-1:0]     data_in [DEPTH];
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic [SEL_WIDTH-1:0] sel;
    logic [SEL_WIDTH-1:0] scan_last;
    logic [WIDTH-1:0]     data_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_WIDTH-1:0] out_sel;
    logic                 out_last;
    logic                 out_err;

    modport master (
        output data_in, in_valid, mode, sel, scan_last, out_ready,
        input  in_ready, data_out, out_valid, out_sel, out_last, out_err
    );

    modport slave (
        input  data_in, in_valid, mode, sel, scan_last, out_ready,
        output in_ready, data_out, out_valid, out_sel, out_last, out_err
    );
endinterface

// File: rtl/pe_mux_seq.sv
// Registered multiplexer: emits one selected element (direct mode) or
// serialises a captured vector over indices 0..scan_last (scan mode).
module pe_mux_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SEL_WIDTH = $clog2(DEPTH)
) (
    input logic          clk,
    input logic          rst,
    pe_mux_seq_if.slave  bus
);

    localparam logic [SEL_WIDTH-1:0] MAX_IDX = SEL_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     buffer [DEPTH];
    logic [SEL_WIDTH-1:0] last_idx;
    logic [WIDTH-1:0]     data_q;
    logic                 valid_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic                 last_q;
    logic                 err_q;

    logic                 out_hs;
    logic                 done;
    logic                 accept;
    logic                 sel_oob;
    logic [SEL_WIDTH-1:0] eff_last;
    logic [SEL_WIDTH-1:0] next_idx;

    // Handshake decode; a new beat may enter only when nothing is held or the final beat leaves now.
    assign out_hs       = valid_q & bus.out_ready;
    assign done         = out_hs & last_q;
    assign bus.in_ready = ~rst & ((state == IDLE) | done);
    assign accept       = bus.in_valid & bus.in_ready;

    // Index helpers: out-of-range direct select and clamped scan end.
    assign sel_oob  = 32'(bus.sel) >= DEPTH;
    assign eff_last = (32'(bus.scan_last) > (DEPTH - 1)) ? MAX_IDX : bus.scan_last;
    assign next_idx = sel_q + SEL_WIDTH'(1);

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;

    // Control FSM with registered output beat and scan capture buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            last_idx <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buffer[i] <= '0;
            end
        end else if (accept) begin
            valid_q <= 1'b1;
            if (!bus.mode) begin
                state  <= DIRECT;
                sel_q  <= bus.sel;
                last_q <= 1'b1;
                err_q  <= sel_oob;
                data_q <= sel_oob ? '0 : bus.data_in[bus.sel];
            end else begin
                state    <= SCAN;
                sel_q    <= '0;
                last_idx <= eff_last;
                last_q   <= (eff_last == '0);
                err_q    <= 1'b0;
                data_q   <= bus.data_in[0];
                for (int i = 0; i < int'(DEPTH); i++) begin
                    buffer[i] <= bus.data_in[i];
                end
            end
        end else if (done) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else if (out_hs && (state == SCAN)) begin
            sel_q  <= next_idx;
            data_q <= buffer[next_idx];
            last_q <= (next_idx == last_idx);
        end
    end

endmodule
